// File: rtl/dcache_pkg.sv
// Shared types and address-split helpers for the write-through data cache (dcache_wt).
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2
  } state_t;

  function automatic int calc_off_w(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

  function automatic int calc_idx_w(input int num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int calc_tag_w(input int addr_w, input int words_per_line, input int num_lines);
    return addr_w - 2 - calc_off_w(words_per_line) - calc_idx_w(num_lines);
  endfunction

  // Extracts a width-bit field starting at lsb; callers size-cast the result.
  function automatic logic [63:0] addr_field(input logic [63:0] addr, input int lsb, input int width);
    return (addr >> lsb) & ((64'd1 << width) - 64'd1);
  endfunction

endpackage

// File: rtl/dcache_store.sv
// Tag, valid and data arrays for dcache_wt: combinational lookup, synchronous word write.
module dcache_store #(
  parameter int NUM_LINES      = 8,
  parameter int WORDS_PER_LINE = 4,
  parameter int IDX_W          = 3,
  parameter int OFF_W          = 2,
  parameter int TAG_W          = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] idx,
  input  logic [OFF_W-1:0] off,
  input  logic [TAG_W-1:0] tag,
  input  logic             wr_en,
  input  logic [31:0]      wr_data,
  input  logic             fill_en,
  output logic             hit,
  output logic [31:0]      rd_data
);

  logic [31:0]          data_q [NUM_LINES][WORDS_PER_LINE];
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q;

  assign hit     = valid_q[idx] && (tag_q[idx] == tag);
  assign rd_data = data_q[idx][off];

  // NOTE: data and tag arrays carry no reset; valid bits alone decide whether contents are meaningful.
  always_ff @(posedge clk) begin
    if (wr_en)   data_q[idx][off] <= wr_data;
    if (fill_en) tag_q[idx]       <= tag;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          valid_q      <= '0;
    else if (fill_en) valid_q[idx] <= 1'b1;
  end

endmodule

// File: rtl/dcache_wt.sv
// Direct-mapped write-through, no-write-allocate data cache with line refill over req/ack.
// Define DCACHE_STATS_EN to add read-hit / read-miss / write counters.
module dcache_wt
  import dcache_pkg::*;
#(
  parameter int NUM_LINES      = 8,
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] ALUOut,
  input  logic [31:0]       WriteData,
  output logic [31:0]       ReadData,
  output logic              dhit,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       stat_rd_hits,
  output logic [31:0]       stat_rd_misses,
  output logic [31:0]       stat_writes
`endif
);

  localparam int OFF_W    = calc_off_w(WORDS_PER_LINE);
  localparam int IDX_W    = calc_idx_w(NUM_LINES);
  localparam int TAG_W    = calc_tag_w(ADDR_W, WORDS_PER_LINE, NUM_LINES);
  localparam int CNT_W    = (OFF_W > 0) ? OFF_W : 1;
  localparam int LINE_LSB = OFF_W + 2;
  localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(WORDS_PER_LINE - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(WORDS_PER_LINE * 4 - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_d, we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [31:0]       wdata_d;

  logic [ADDR_W-1:0] lk_addr;
  logic [IDX_W-1:0]  lk_idx;
  logic [CNT_W-1:0]  lk_off;
  logic [TAG_W-1:0]  lk_tag;
  logic              hit, wr_en, fill_en;
  logic [31:0]       rd_data, wr_data;

  // Outside IDLE the in-flight mem_addr carries the latched tag/index, so it drives the lookup.
  assign lk_addr = (state_q == IDLE) ? ALUOut : mem_addr;
  assign lk_off  = CNT_W'(addr_field(64'(lk_addr), 2, OFF_W));
  assign lk_idx  = IDX_W'(addr_field(64'(lk_addr), LINE_LSB, IDX_W));
  assign lk_tag  = TAG_W'(addr_field(64'(lk_addr), LINE_LSB + IDX_W, TAG_W));

  dcache_store #(
    .NUM_LINES      (NUM_LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .IDX_W          (IDX_W),
    .OFF_W          (CNT_W),
    .TAG_W          (TAG_W)
  ) u_store (
    .clk     (clk),
    .rst     (reset),
    .idx     (lk_idx),
    .off     (lk_off),
    .tag     (lk_tag),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .fill_en (fill_en),
    .hit     (hit),
    .rd_data (rd_data)
  );

  assign ReadData = (state_q == IDLE && hit) ? rd_data : 32'd0;

  // NOTE: every combinational output is given a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = mem_req;
    we_d    = mem_we;
    addr_d  = mem_addr;
    wdata_d = mem_wdata;
    dhit    = 1'b1;
    wr_en   = 1'b0;
    wr_data = mem_rdata;
    fill_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (MemWrite) begin
          dhit    = 1'b0;
          state_d = WRITE;
          req_d   = 1'b1;
          we_d    = 1'b1;
          addr_d  = ALUOut;
          wdata_d = WriteData;
        end else if (MemRead && !hit) begin
          dhit    = 1'b0;
          state_d = REFILL;
          cnt_d   = '0;
          req_d   = 1'b1;
          we_d    = 1'b0;
          addr_d  = ALUOut & LINE_MASK;
        end
      end
      REFILL: begin
        dhit = 1'b0;
        if (mem_ack) begin
          wr_en = 1'b1;
          if (cnt_q == LAST_WORD) begin
            fill_en = 1'b1;
            req_d   = 1'b0;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d  = cnt_q + 1'b1;
            addr_d = mem_addr + ADDR_W'(4);
          end
        end
      end
      WRITE: begin
        dhit = mem_ack;
        if (mem_ack) begin
          wr_en   = hit;
          wr_data = mem_wdata;
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_req   <= req_d;
      mem_we    <= we_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_rd_hits   <= '0;
      stat_rd_misses <= '0;
      stat_writes    <= '0;
    end else begin
      if (state_q == IDLE && MemRead && !MemWrite && hit)  stat_rd_hits   <= stat_rd_hits + 32'd1;
      if (state_q == IDLE && MemRead && !MemWrite && !hit) stat_rd_misses <= stat_rd_misses + 32'd1;
      if (state_q == WRITE && mem_ack)                     stat_writes    <= stat_writes + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_wt.sv
// Directed bench for dcache_wt with a latency-programmable req/ack memory model.
module tb_dcache_wt;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [31:0] ALUOut, WriteData, ReadData;
  logic        dhit, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ack = 1'b0;
`ifdef DCACHE_STATS_EN
  logic [31:0] stat_rd_hits, stat_rd_misses, stat_writes;
`endif

  dcache_wt dut (
    .clk       (clk),
    .reset     (reset),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .ALUOut    (ALUOut),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .dhit      (dhit),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
`ifdef DCACHE_STATS_EN
    ,
    .stat_rd_hits   (stat_rd_hits),
    .stat_rd_misses (stat_rd_misses),
    .stat_writes    (stat_writes)
`endif
  );

  always #5 clk = ~clk;

  // Memory model: unwritten words read as 0xA5000000 + byte address.
  int          lat = 2;
  int          wcnt = 0;
  logic [31:0] mem [1024];
  bit          written [1024];
  logic [31:0] rd_log[$];
  logic [31:0] wr_addr_log[$];
  logic [31:0] wr_data_log[$];

  always @(negedge clk) begin
    if (reset) begin
      mem_ack = 1'b0;
      wcnt    = 0;
    end else begin
      mem_ack = 1'b0;
      if (mem_req) begin
        wcnt++;
        if (wcnt >= lat) begin
          wcnt    = 0;
          mem_ack = 1'b1;
          if (mem_we) begin
            mem[mem_addr[11:2]]     = mem_wdata;
            written[mem_addr[11:2]] = 1'b1;
            wr_addr_log.push_back(mem_addr);
            wr_data_log.push_back(mem_wdata);
          end else begin
            mem_rdata = written[mem_addr[11:2]] ? mem[mem_addr[11:2]] : 32'hA500_0000 + mem_addr;
            rd_log.push_back(mem_addr);
          end
        end
      end
    end
  end

  int n_checks = 0;
  int n_pass   = 0;
  int exp_hits = 0, exp_misses = 0, exp_writes = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

`ifdef DCACHE_STATS_EN
  task automatic check_stats(input string tag);
    check({tag, "_hits"},   stat_rd_hits,   exp_hits);
    check({tag, "_misses"}, stat_rd_misses, exp_misses);
    check({tag, "_writes"}, stat_writes,    exp_writes);
  endtask
`endif

  // Starts just after a negedge; counts dhit=0 cycles until the load completes.
  task automatic do_load(input string tag, input logic [31:0] a, input logic [31:0] exp_data,
                         input int exp_stall);
    int stall = 0;
    int n0 = rd_log.size();
    ALUOut = a; MemRead = 1'b1; MemWrite = 1'b0;
    #1;
    while (!dhit && stall < 200) begin
      @(negedge clk); #1;
      stall++;
    end
    check({tag, "_stall"}, stall, exp_stall);
    check({tag, "_data"}, ReadData, exp_data);
    check({tag, "_nreads"}, rd_log.size() - n0, (exp_stall > 0) ? 4 : 0);
    if (exp_stall > 0 && rd_log.size() >= n0 + 4) begin
      check({tag, "_first_addr"}, rd_log[n0], a & 32'hFFFF_FFF0);
      check({tag, "_last_addr"}, rd_log[n0+3], (a & 32'hFFFF_FFF0) + 32'hC);
    end
    exp_hits++;
    if (exp_stall > 0) exp_misses++;
    @(negedge clk); #1;
    MemRead = 1'b0;
  endtask

  task automatic do_store(input string tag, input logic [31:0] a, input logic [31:0] d,
                          input logic also_read, input int exp_stall);
    int stall = 0;
    int n0 = wr_addr_log.size();
    int r0 = rd_log.size();
    ALUOut = a; WriteData = d; MemWrite = 1'b1; MemRead = also_read;
    #1;
    while (!dhit && stall < 200) begin
      @(negedge clk); #1;
      stall++;
    end
    check({tag, "_stall"}, stall, exp_stall);
    check({tag, "_nwrites"}, wr_addr_log.size() - n0, 1);
    check({tag, "_nreads"}, rd_log.size() - r0, 0);
    if (wr_addr_log.size() > n0) begin
      check({tag, "_waddr"}, wr_addr_log[n0], a);
      check({tag, "_wdata"}, wr_data_log[n0], d);
    end
    exp_writes++;
    @(negedge clk); #1;
    MemWrite = 1'b0; MemRead = 1'b0;
    #1;
    check({tag, "_idle_dhit"}, dhit, 1'b1);
    check({tag, "_idle_req"}, mem_req, 1'b0);
  endtask

  initial begin
    int n0;
    int guard;
    reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; ALUOut = '0; WriteData = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_req", mem_req, 1'b0);
    check("rst_we", mem_we, 1'b0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    reset = 1'b0;
    #1;
    check("rst_dhit", dhit, 1'b1);
    check("rst_rdata", ReadData, 32'd0);
`ifdef DCACHE_STATS_EN
    check_stats("rst");
`endif
    @(negedge clk); #1;

    lat = 2;
    do_load("ld40_miss", 32'h40, 32'hA500_0040, 9);
    do_load("ld48_hit", 32'h48, 32'hA500_0048, 0);

    lat = 3;
    do_store("st44_hit", 32'h44, 32'hDEAD_BEEF, 1'b0, 3);
    do_load("ld44_hit", 32'h44, 32'hDEAD_BEEF, 0);

    do_store("st400_miss", 32'h400, 32'h1122_3344, 1'b0, 3);
    lat = 2;
    do_load("ld400_miss", 32'h400, 32'h1122_3344, 9);

    do_load("ld40_hit", 32'h40, 32'hA500_0040, 0);
    do_load("ldC0_evict", 32'hC0, 32'hA500_00C0, 9);
    do_load("ld40_remiss", 32'h40, 32'hA500_0040, 9);
    do_load("ld44_wthru", 32'h44, 32'hDEAD_BEEF, 0);

    lat = 1;
    do_store("st48_both", 32'h48, 32'h0000_0055, 1'b1, 1);
    do_load("ld48_upd", 32'h48, 32'h0000_0055, 0);
`ifdef DCACHE_STATS_EN
    check_stats("mid");
`endif

    // Abort a refill by asserting reset while the second word is outstanding.
    lat = 2;
    n0 = rd_log.size();
    ALUOut = 32'h100; MemRead = 1'b1;
    guard = 0;
    while (rd_log.size() < n0 + 1 && guard < 50) begin
      @(negedge clk); #1;
      guard++;
    end
    check("abort_word0_seen", rd_log.size() - n0, 1);
    @(negedge clk); #1;
    check("abort_req_before", mem_req, 1'b1);
    reset = 1'b1; MemRead = 1'b0;
    #1;
    check("abort_req_drop", mem_req, 1'b0);
    check("abort_addr", mem_addr, 32'd0);
    check("abort_dhit", dhit, 1'b1);
    exp_hits = 0; exp_misses = 0; exp_writes = 0;
    @(negedge clk); #1;
    reset = 1'b0;
    @(negedge clk); #1;
    do_load("ld40_post_rst", 32'h40, 32'hA500_0040, 9);
    do_load("ld100_post_rst", 32'h100, 32'hA500_0100, 9);
`ifdef DCACHE_STATS_EN
    check_stats("end");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
